// File: rtl/chip8_cpu.sv
// CHIP-8 ALU core: two-state FETCH/EXEC machine over a 16 x 8-bit register file (VF = flag).
// Optional macro CHIP8_SHIFT_VY_EN: 8XY6/8XYE shift VY instead of VX.
module chip8_cpu (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic [3:0]  testIn1,
    input  logic [3:0]  testIn2,
    output logic [7:0]  testOut1,
    output logic [7:0]  testOut2
);

    localparam int unsigned REG_W   = 8;
    localparam int unsigned NUM_REG = 16;
    localparam int unsigned OP_W    = 16;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [OP_W-1:0]    r_opcode;
    logic [REG_W-1:0]   r_v [NUM_REG];

    logic [3:0]         w_x;
    logic [3:0]         w_y;
    logic [3:0]         w_n;
    logic [REG_W-1:0]   w_nn;
    logic [REG_W-1:0]   w_vx;
    logic [REG_W-1:0]   w_vy;
    logic [REG_W-1:0]   w_shift_src;
    logic [REG_W:0]     w_add_xy;
    logic [REG_W:0]     w_sub_xy;
    logic [REG_W:0]     w_sub_yx;

    logic               w_x_we;
    logic [REG_W-1:0]   w_x_wd;
    logic               w_f_we;
    logic [REG_W-1:0]   w_f_wd;

    assign w_x  = r_opcode[11:8];
    assign w_y  = r_opcode[7:4];
    assign w_n  = r_opcode[3:0];
    assign w_nn = r_opcode[7:0];
    assign w_vx = r_v[w_x];
    assign w_vy = r_v[w_y];

`ifdef CHIP8_SHIFT_VY_EN
    assign w_shift_src = w_vy;
`else
    assign w_shift_src = w_vx;
`endif

    // Borrow lands in bit 8, so the no-borrow flag is its inverse.
    assign w_add_xy = 9'(w_vx) + 9'(w_vy);
    assign w_sub_xy = 9'(w_vx) - 9'(w_vy);
    assign w_sub_yx = 9'(w_vy) - 9'(w_vx);

    assign testOut1 = r_v[testIn1];
    assign testOut2 = r_v[testIn2];

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_FETCH;
            default: w_next_state = S_FETCH;
        endcase
    end

    // Decode of the latched opcode into register-file write strobes.
    always_comb begin
        w_x_we = 1'b0;
        w_x_wd = '0;
        w_f_we = 1'b0;
        w_f_wd = '0;
        if (r_state == S_EXEC) begin
            case (r_opcode[15:12])
                4'h6: begin
                    w_x_we = 1'b1;
                    w_x_wd = w_nn;
                end
                4'h7: begin
                    w_x_we = 1'b1;
                    w_x_wd = w_vx + w_nn;
                end
                4'h8: begin
                    case (w_n)
                        4'h0: begin w_x_we = 1'b1; w_x_wd = w_vy; end
                        4'h1: begin w_x_we = 1'b1; w_x_wd = w_vx | w_vy; end
                        4'h2: begin w_x_we = 1'b1; w_x_wd = w_vx & w_vy; end
                        4'h3: begin w_x_we = 1'b1; w_x_wd = w_vx ^ w_vy; end
                        4'h4: begin
                            w_x_we = 1'b1;
                            w_x_wd = w_add_xy[7:0];
                            w_f_we = 1'b1;
                            w_f_wd = {7'd0, w_add_xy[8]};
                        end
                        4'h5: begin
                            w_x_we = 1'b1;
                            w_x_wd = w_sub_xy[7:0];
                            w_f_we = 1'b1;
                            w_f_wd = {7'd0, ~w_sub_xy[8]};
                        end
                        4'h7: begin
                            w_x_we = 1'b1;
                            w_x_wd = w_sub_yx[7:0];
                            w_f_we = 1'b1;
                            w_f_wd = {7'd0, ~w_sub_yx[8]};
                        end
                        4'h6: begin
                            w_x_we = 1'b1;
                            w_x_wd = {1'b0, w_shift_src[7:1]};
                            w_f_we = 1'b1;
                            w_f_wd = {7'd0, w_shift_src[0]};
                        end
                        4'hE: begin
                            w_x_we = 1'b1;
                            w_x_wd = {w_shift_src[6:0], 1'b0};
                            w_f_we = 1'b1;
                            w_f_wd = {7'd0, w_shift_src[7]};
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            r_opcode <= '0;
        end else if (r_state == S_FETCH) begin
            r_opcode <= instruction;
        end
    end

    // Flag write is issued last so it overrides the result when X = F.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REG; i++) begin
                r_v[i] <= '0;
            end
        end else begin
            if (w_x_we) begin
                r_v[w_x] <= w_x_wd;
            end
            if (w_f_we) begin
                r_v[NUM_REG-1] <= w_f_wd;
            end
        end
    end

endmodule

// File: tb/tb_chip8_cpu.sv
// Self-checking bench for chip8_cpu: directed vector table, corner sequences, random ops vs model.
module tb_chip8_cpu;

    logic        cpu_clk;
    logic        reset;
    logic [15:0] instruction;
    logic [3:0]  testIn1;
    logic [3:0]  testIn2;
    logic [7:0]  testOut1;
    logic [7:0]  testOut2;

    int n_checks = 0;
    int n_errors = 0;
    int m_v [16];

    typedef struct {
        logic [15:0] op;
        int          idx;
        logic [7:0]  exp_val;
        bit          chk_f;
        logic [7:0]  exp_f;
    } vec_t;

    vec_t tab [15];

    chip8_cpu dut (
        .cpu_clk    (cpu_clk),
        .reset      (reset),
        .instruction(instruction),
        .testIn1    (testIn1),
        .testIn2    (testIn2),
        .testOut1   (testOut1),
        .testOut2   (testOut2)
    );

    initial cpu_clk = 1'b0;
    always #10 cpu_clk = ~cpu_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s V%0h: got %02h, want %02h", nm, idx, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_v[i] = 0;
    endtask

    task automatic model_exec(input logic [15:0] op);
        int x, y, n, nn, vx, vy, s, src;
        x  = int'(op[11:8]);
        y  = int'(op[7:4]);
        n  = int'(op[3:0]);
        nn = int'(op[7:0]);
        vx = m_v[x];
        vy = m_v[y];
`ifdef CHIP8_SHIFT_VY_EN
        src = vy;
`else
        src = vx;
`endif
        if (op[15:12] == 4'h6) m_v[x] = nn;
        else if (op[15:12] == 4'h7) m_v[x] = (vx + nn) % 256;
        else if (op[15:12] == 4'h8) begin
            case (n)
                0: m_v[x] = vy;
                1: m_v[x] = vx | vy;
                2: m_v[x] = vx & vy;
                3: m_v[x] = vx ^ vy;
                4: begin s = vx + vy; m_v[x] = s % 256; m_v[15] = (s > 255) ? 1 : 0; end
                5: begin m_v[x] = (vx - vy + 256) % 256; m_v[15] = (vx >= vy) ? 1 : 0; end
                7: begin m_v[x] = (vy - vx + 256) % 256; m_v[15] = (vy >= vx) ? 1 : 0; end
                6: begin m_v[x] = src / 2; m_v[15] = src % 2; end
                14: begin m_v[x] = (src * 2) % 256; m_v[15] = src / 128; end
                default: ;
            endcase
        end
    endtask

    // One opcode spans exactly a FETCH edge and an EXEC edge.
    task automatic exec_op(input logic [15:0] op);
        instruction = op;
        @(posedge cpu_clk);
        @(posedge cpu_clk);
        #1;
        model_exec(op);
    endtask

    task automatic compare_all(input string nm);
        for (int i = 0; i < 16; i += 2) begin
            testIn1 = 4'(i);
            testIn2 = 4'(i + 1);
            #1;
            chk(nm, i, testOut1, 8'(m_v[i]));
            chk(nm, i + 1, testOut2, 8'(m_v[i + 1]));
        end
    endtask

    logic [15:0] rop;
    int          k;
    int          valid_n [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 14};
    int          bad_n   [7] = '{8, 9, 10, 11, 12, 13, 15};
    int          top;

    initial begin
        tab[0]  = '{16'h6122, 1,  8'h22, 1'b0, 8'h00};
        tab[1]  = '{16'h6020, 0,  8'h20, 1'b0, 8'h00};
        tab[2]  = '{16'h8014, 0,  8'h42, 1'b1, 8'h00};
        tab[3]  = '{16'h8014, 0,  8'h64, 1'b1, 8'h00};
        tab[4]  = '{16'h8013, 0,  8'h46, 1'b0, 8'h00};
        tab[5]  = '{16'h8015, 0,  8'h24, 1'b1, 8'h01};
        tab[6]  = '{16'h62F0, 2,  8'hF0, 1'b0, 8'h00};
        tab[7]  = '{16'h6320, 3,  8'h20, 1'b0, 8'h00};
        tab[8]  = '{16'h8234, 2,  8'h10, 1'b1, 8'h01};
        tab[9]  = '{16'h6410, 4,  8'h10, 1'b0, 8'h00};
        tab[10] = '{16'h6520, 5,  8'h20, 1'b0, 8'h00};
        tab[11] = '{16'h8455, 4,  8'hF0, 1'b1, 8'h00};
        tab[12] = '{16'h6681, 6,  8'h81, 1'b0, 8'h00};
        tab[13] = '{16'h866E, 6,  8'h02, 1'b1, 8'h01};
        tab[14] = '{16'h8F14, 15, 8'h00, 1'b1, 8'h00};

        reset       = 1'b1;
        instruction = 16'h0000;
        testIn1     = 4'd0;
        testIn2     = 4'd1;
        model_reset();
        repeat (2) @(posedge cpu_clk);
        #1;
        reset = 1'b0;
        compare_all("reset_state");

        for (int i = 0; i < 15; i++) begin
            exec_op(tab[i].op);
            testIn1 = 4'(tab[i].idx);
            testIn2 = 4'd15;
            #1;
            chk($sformatf("vec%0d_%04h", i, tab[i].op), tab[i].idx, testOut1, tab[i].exp_val);
            if (tab[i].chk_f)
                chk($sformatf("vec%0d_%04h_flag", i, tab[i].op), 15, testOut2, tab[i].exp_f);
        end

        // Write must not land on the FETCH edge, only on the following EXEC edge.
        instruction = 16'h6333;
        @(posedge cpu_clk);
        #1;
        testIn1 = 4'd3;
        #1;
        chk("latency_before_exec", 3, testOut1, 8'h20);
        @(posedge cpu_clk);
        #1;
        model_exec(16'h6333);
        chk("latency_after_exec", 3, testOut1, 8'h33);

        exec_op(16'h6850);
        exec_op(16'h6903);
        exec_op(16'h8896);
        compare_all("shift_right_src");
        exec_op(16'h889E);
        compare_all("shift_left_src");

        // Reset during EXEC aborts the pending write-back.
        exec_op(16'h6755);
        instruction = 16'h7701;
        @(posedge cpu_clk);
        #1;
        reset = 1'b1;
        @(posedge cpu_clk);
        #1;
        reset = 1'b0;
        model_reset();
        compare_all("reset_in_exec");

        exec_op(16'h6155);
        exec_op(16'h6266);
        exec_op(16'h5120);
        compare_all("noop_5120");
        exec_op(16'h8128);
        compare_all("noop_8xy8");
        exec_op(16'h6A77);
        compare_all("after_noop_align");

        for (int t = 0; t < 300; t++) begin
            k = $urandom_range(0, 9);
            if (k <= 2)
                rop = {4'h6, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
            else if (k == 3)
                rop = {4'h7, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
            else if (k <= 7)
                rop = {4'h8, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'(valid_n[$urandom_range(0, 8)])};
            else if (k == 8)
                rop = {4'h8, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'(bad_n[$urandom_range(0, 6)])};
            else begin
                top = $urandom_range(0, 15);
                if (top >= 6 && top <= 8) top = 10;
                rop = {4'(top), 12'($urandom_range(0, 4095))};
            end
            exec_op(rop);
            compare_all($sformatf("rand%0d_%04h", t, rop));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
